// File: rtl/uart_tx_bus.sv
// Bus-mapped 8N1 UART transmitter: a write to TX_ADDR queues a byte, and a read at STATUS_ADDR returns the status word.
// Optional CTS gating is compiled in with `define UART_TX_FLOW_CTRL_EN.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for DIVISOR cycles
// DATA  | eight data bits, LSB first, DIVISOR cycles each
// STOP  | stop bit (high); chains straight into START if more data is queued
module uart_tx_bus #(
  parameter int          CLOCK_FREQ  = 25000000,
  parameter int          BAUD        = 115200,
  parameter logic [63:0] TX_ADDR     = 64'h0000_0000_0000_F100,
  parameter logic [63:0] STATUS_ADDR = 64'h0000_0000_0000_F108,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [63:0] address,
  input  logic        read,
  input  logic        write,
`ifdef UART_TX_FLOW_CTRL_EN
  input  logic        cts_n,
`endif
  output logic        uart_txd
);

  localparam int DIVISOR = CLOCK_FREQ / BAUD;
  localparam int BAUD_W  = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              srd_q;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic        status_sel, tx_sel, full, push, pop, ovf_set;
  logic        cts_ok, cts_bit, can_start, baud_done;
  logic [2:0]  bit_nx;
  logic [4:0]  count_ext;
  logic [63:0] status_word;
  logic        unused_data;

  assign status_sel = read && (address == STATUS_ADDR);
  assign tx_sel     = write && (address == TX_ADDR);
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign push       = tx_sel && !full;
  assign ovf_set    = tx_sel && full;
  assign baud_done  = (baud_q == BAUD_W'(DIVISOR - 1));
  assign bit_nx     = bit_q + 3'd1;
  assign unused_data = ^data[63:8];

`ifdef UART_TX_FLOW_CTRL_EN
  // Resets to "not clear to send" so nothing leaves before the sync settles.
  logic [1:0] cts_sync_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cts_sync_q <= 2'b11;
    else        cts_sync_q <= {cts_sync_q[0], cts_n};
  end
  assign cts_bit = cts_sync_q[1];
  assign cts_ok  = !cts_sync_q[1];
`else
  assign cts_bit = 1'b0;
  assign cts_ok  = 1'b1;
`endif

  assign can_start = (count_q != '0) && cts_ok;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = 3'd0;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = ST_START;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_nx;
            txd_d = shift_q[bit_nx];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (can_start) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
            txd_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    // Only the first edge of a status read clears; a same-edge overflow wins.
    if (ovf_set)                  ovf_d = 1'b1;
    else if (status_sel && !srd_q) ovf_d = 1'b0;
    else                          ovf_d = ovf_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      srd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      srd_q    <= status_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= data[7:0];
  end

  assign count_ext   = 5'(count_q);
  assign status_word = {52'b0, count_ext, 3'b0, cts_bit, ovf_q, full,
                        (count_q != '0) || (state_q != ST_IDLE)};
  assign data        = status_sel ? status_word : 64'bz;
  assign uart_txd    = txd_q;

endmodule

// File: tb/tb_uart_tx_bus.sv
// Directed bench for uart_tx_bus at DIVISOR = 10 (1000 Hz clock, 100 baud).
// The data net is pulled up, so a released bus reads as all ones.
module tb_uart_tx_bus;

  localparam logic [63:0] TX_ADDR     = 64'h0000_0000_0000_F100;
  localparam logic [63:0] STATUS_ADDR = 64'h0000_0000_0000_F108;
  localparam logic [63:0] BUS_FLOAT   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock;
  logic        reset;
  logic [63:0] address;
  logic        read;
  logic        write;
  logic        drv_en;
  logic [63:0] drv_val;
  logic        uart_txd;
  tri1  [63:0] data;

  int checks;
  int failures;

  assign data = drv_en ? drv_val : 64'bz;

`ifdef UART_TX_FLOW_CTRL_EN
  logic cts_n;
`endif

  uart_tx_bus #(
    .CLOCK_FREQ (1000),
    .BAUD       (100),
    .TX_ADDR    (TX_ADDR),
    .STATUS_ADDR(STATUS_ADDR),
    .FIFO_DEPTH (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .data    (data),
    .address (address),
    .read    (read),
    .write   (write),
`ifdef UART_TX_FLOW_CTRL_EN
    .cts_n   (cts_n),
`endif
    .uart_txd(uart_txd)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_status(output logic [63:0] v);
    address = STATUS_ADDR;
    read    = 1'b1;
    #1;
    v       = data;
    read    = 1'b0;
    address = 64'h0;
  endtask

  task automatic bus_write(input logic [63:0] addr, input logic [7:0] val);
    address = addr;
    drv_val = {56'hA5A5_5A5A_C3C3_3C, val};
    drv_en  = 1'b1;
    write   = 1'b1;
    @(posedge clock);
    #1;
    write   = 1'b0;
    drv_en  = 1'b0;
    address = 64'h0;
  endtask

  // Samples each of the 10 frame levels four cycles into its bit period.
  task automatic expect_frame(input logic [7:0] b, input int lead, input string tag);
    logic [63:0] s;
    logic        exp;
    repeat (lead) @(posedge clock);
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      exp = 1'b0;
      else if (k == 9) exp = 1'b1;
      else             exp = b[k-1];
      check($sformatf("%s_lvl%0d", tag, k), 64'(uart_txd), 64'(exp));
      read_status(s);
      check($sformatf("%s_busy%0d", tag, k), 64'(s[0]), 64'h1);
      repeat (10) @(posedge clock);
      #1;
    end
  endtask

  task automatic watch_idle(input int n, input string tag);
    int low;
    low = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
      if (uart_txd == 1'b0) low++;
    end
    check(tag, 64'(low), 64'h0);
  endtask

  initial begin
    logic [63:0] s;
    checks   = 0;
    failures = 0;
    clock    = 1'b0;
    reset    = 1'b1;
    address  = 64'h0;
    read     = 1'b0;
    write    = 1'b0;
    drv_en   = 1'b0;
    drv_val  = 64'h0;
`ifdef UART_TX_FLOW_CTRL_EN
    cts_n    = 1'b0;
`endif
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_txd", 64'(uart_txd), 64'h1);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    read_status(s);
    check("status_after_reset", s, 64'h0);

    address = TX_ADDR;
    read    = 1'b1;
    #1;
    check("read_other_addr_float", data, BUS_FLOAT);
    read    = 1'b0;
    address = STATUS_ADDR;
    #1;
    check("no_read_strobe_float", data, BUS_FLOAT);
    address = 64'h0;

    // Single byte 0x55
    bus_write(TX_ADDR, 8'h55);
    read_status(s);
    check("status_queued_one", s, 64'h81);
    expect_frame(8'h55, 5, "single55");
    check("single_idle_txd", 64'(uart_txd), 64'h1);
    read_status(s);
    check("single_status_done", s, 64'h0);
    watch_idle(20, "single_no_extra");

    // Back-to-back 0xA3, 0x0F
    bus_write(TX_ADDR, 8'hA3);
    bus_write(TX_ADDR, 8'h0F);
    expect_frame(8'hA3, 4, "b2b_a3");
    expect_frame(8'h0F, 0, "b2b_0f");
    read_status(s);
    check("b2b_status_done", s, 64'h0);

    // Write to another address must not transmit
    bus_write(STATUS_ADDR, 8'h00);
    watch_idle(120, "wrong_addr_no_tx");
    read_status(s);
    check("wrong_addr_status", s, 64'h0);

    // Overflow: 0x01 goes to the shifter, 0x02..0x09 fill the FIFO, 0x0A is dropped
    for (int i = 1; i <= 9; i++) bus_write(TX_ADDR, 8'(i));
    read_status(s);
    check("fifo_full_no_ovf", s, 64'h403);
    bus_write(TX_ADDR, 8'h0A);
    read_status(s);
    check("fifo_full_ovf", s, 64'h407);
    address = STATUS_ADDR;
    read    = 1'b1;
    @(posedge clock);
    #1;
    check("ovf_cleared_by_read", data, 64'h403);
    read    = 1'b0;
    address = 64'h0;
    read_status(s);
    check("ovf_second_read", s, 64'h403);
    expect_frame(8'h02, 95, "ovf_f02");
    for (int i = 3; i <= 9; i++) expect_frame(8'(i), 0, $sformatf("ovf_f%02h", i));
    read_status(s);
    check("ovf_drained_status", s, 64'h0);
    watch_idle(100, "ovf_0a_never_sent");

    // Reset at cycle 35 of a 0xFF frame with 0x00 still queued
    bus_write(TX_ADDR, 8'hFF);
    bus_write(TX_ADDR, 8'h00);
    repeat (34) @(posedge clock);
    #1;
    check("ff_frame_bit2", 64'(uart_txd), 64'h1);
    #2 reset = 1'b0;
    #1;
    check("reset_mid_ff_txd", 64'(uart_txd), 64'h1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    read_status(s);
    check("reset_mid_ff_status", s, 64'h0);
    watch_idle(150, "reset_mid_ff_no_tx");

    // Reset during a start bit must raise the line without waiting for a clock edge
    bus_write(TX_ADDR, 8'h00);
    repeat (3) @(posedge clock);
    #1;
    check("start_bit_low", 64'(uart_txd), 64'h0);
    #2 reset = 1'b0;
    #1;
    check("reset_async_txd", 64'(uart_txd), 64'h1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    read_status(s);
    check("reset_start_status", s, 64'h0);
    watch_idle(150, "reset_start_no_tx");

`ifdef UART_TX_FLOW_CTRL_EN
    begin
      logic fell;
      cts_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      bus_write(TX_ADDR, 8'h41);
      watch_idle(200, "cts_hold_no_tx");
      read_status(s);
      check("cts_hold_status", s, 64'h89);
      cts_n = 1'b0;
      fell  = 1'b0;
      for (int i = 0; i < 10 && !fell; i++) begin
        @(posedge clock);
        #1;
        if (uart_txd == 1'b0) fell = 1'b1;
      end
      check("cts_start_seen", 64'(fell), 64'h1);
      cts_n = 1'b1;
      expect_frame(8'h41, 4, "cts_f41");
      watch_idle(50, "cts_after_frame");
      read_status(s);
      check("cts_final_status", s, 64'h8);
      cts_n = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_bus.md
Name: uart_tx_bus

Overview:
- Memory-mapped RS-232 transmitter on the shared 64-bit processor data/address bus. It is the transmit counterpart to the board's receive-side peripherals.
- Processor writes bytes to a TX register; bytes are buffered in a small FIFO and serialised 8N1, LSB first, onto UART_TXD.
- A status register readable over the same bus reports busy, full and overflow.
- Instantiated in the DE0 top level alongside the GPU, keyboard and GPIO peripherals, clocked from the 25 MHz clock.

Parameters:
- CLOCK_FREQ, 25000000, input clock frequency in Hz.
- BAUD, 115200, line rate. DIVISOR = CLOCK_FREQ/BAUD (integer truncation, 217 at defaults); must be >= 2.
- TX_ADDR, 64'h0000_0000_0000_F100, write address for transmit data.
- STATUS_ADDR, 64'h0000_0000_0000_F108, read address for status.
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..16.

Ports:
- clock  input  1  system clock (25 MHz at top level).
- reset  input  1  asynchronous, active-low reset.
- data  inout  64  shared processor data bus.
- address  input  64  shared processor address bus.
- read  input  1  bus read strobe.
- write  input  1  bus write strobe.
- uart_txd  output  1  serial output; idles high.

Behaviour:
- Reset (reset low, asynchronous):
  - uart_txd = 1, state IDLE, FIFO empty (count 0), overflow = 0, baud/bit counters 0.
  - data is high-Z.
  - Asserting reset mid-frame forces uart_txd to 1 immediately; the partial byte and all FIFO contents are discarded.
- Bus write:
  - On a rising edge with write = 1 and address == TX_ADDR, data[7:0] is pushed; data[63:8] is ignored.
  - Full is evaluated on the pre-edge count. A write while full is dropped and sets sticky overflow = 1, even if a pop occurs in the same cycle.
  - Writes to any other address are ignored.
- Bus read:
  - Combinational drive: while read = 1 and address == STATUS_ADDR, data = {52'b0, count[4:0], 4'b0, overflow, full, busy}. Otherwise data = 64'bz.
  - busy = FIFO non-empty OR state != IDLE.
  - full = (count == FIFO_DEPTH).
  - overflow clears on the rising edge ending a status read cycle, i.e. the first edge with read = 1 at STATUS_ADDR. It stays set if an overflowing write lands on that same edge.
- Simultaneous push and pop (FIFO not full): both take effect; count unchanged.
- State machine, with baud counter counting 0..DIVISOR-1:
  - IDLE: uart_txd = 1. If the FIFO is non-empty, pop into the shift register and go to START on that edge.
  - START: uart_txd = 0 for DIVISOR cycles, then DATA with bit index 0.
  - DATA: uart_txd = shift[bit index] for DIVISOR cycles per bit. After bit 7, go to STOP.
  - STOP: uart_txd = 1 for DIVISOR cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.
- Latency: for a write edge to an empty, idle block, the FIFO goes non-empty that edge, the pop happens on the next edge, and uart_txd falls right after it (1 cycle from write edge to start bit).
- Frame = 10 × DIVISOR cycles.
- uart_txd is driven from a flop (glitch-free).
- Pointers wrap modulo FIFO_DEPTH; count is one bit wider than the pointers.

Optional Feature:
- Macro: UART_TX_FLOW_CTRL_EN.
- Defined:
  - Adds port cts_n (input, 1), fed from the board's RTS line and passed through a 2-flop synchroniser.
  - IDLE and the STOP-to-START transition begin a new frame only when the synchronised cts_n = 0. While it is 1, the block waits in IDLE with uart_txd = 1 and the FIFO retained.
  - A frame already in progress always completes.
  - Status bit 3 = synchronised cts_n.
- Undefined: cts_n port absent; frames start unconditionally; status bit 3 reads 0.

Test Plan:
All scenarios use CLOCK_FREQ=1000, BAUD=100, so DIVISOR = 10.
- Single byte: write 0x55 to TX_ADDR. uart_txd, one level per 10 cycles: 0,1,0,1,0,1,0,1,0,1. Then idle high; busy = 1 throughout the 100-cycle frame, then 0.
- Back-to-back: write 0xA3, 0x0F on consecutive cycles. Two frames with no idle gap between stop and start. Bits LSB-first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Overflow: write 9 bytes (0x01..0x09) on consecutive cycles with the line stalled.
  - First byte enters the shifter; the next 8 fill the FIFO, so no overflow.
  - Repeat with a 10th write: status reads full = 1, overflow = 1.
  - Second status read shows overflow = 0; 0x0A is never transmitted.
- Bus hygiene:
  - Read at STATUS_ADDR after reset returns 64'h0.
  - Read at any other address leaves data = Z.
  - Write to TX_ADDR+8 causes no transmission.
- Reset mid-frame: assert reset at cycle 35 of a 0xFF frame. uart_txd = 1 asynchronously, status = 0 after release, no further frame.
- UART_TX_FLOW_CTRL_EN: hold cts_n = 1 and write 0x41; uart_txd stays 1 for 200 cycles. Drop cts_n; the start bit appears within 3 cycles plus sync delay. Raising cts_n mid-frame does not truncate it.
